// File: rtl/sdram_reset_seq.sv
// sdram_reset_seq
//
// Reset and power-up sequencer for the 90 MHz SDRAM clock domain. It sits
// directly behind the SDRAM PLL and does four things:
//   - synchronizes and debounces the PLL lock flag
//   - holds the 90 MHz logic in reset until lock has been stable for RST_HOLD cycles
//   - times the SDRAM power-up wait
//   - emits a single-cycle init_start pulse for the SDRAM controller
// Losing lock drops everything back to reset and bumps a saturating debug counter.
//
// Ports
//   clk           in   90 MHz clock (PLL output)
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL lock flag, asynchronous to clk
//   sys_rst_n     out  active-low reset for the 90 MHz logic (high in PWRUP/READY)
//   init_start    out  one-cycle pulse on entry to READY
//   sdram_ready   out  high while in READY
//   lock_loss_cnt out  saturating count of lock-loss events

module sdram_reset_seq #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned LOCK_FILTER  = 4,
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned PWRUP_CYCLES = 18000,
  parameter int unsigned CNT_W        = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       sys_rst_n,
  output logic       init_start,
  output logic       sdram_ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned      FiltW     = $clog2(LOCK_FILTER + 1);
  localparam logic [FiltW-1:0] FiltLast  = FiltW'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] PwrupLast = CNT_W'(PWRUP_CYCLES - 1);

  typedef enum logic [1:0] {
    StWaitLock,
    StHold,
    StPwrup,
    StReady
  } state_e;

  // ---------------------------------------------------------------------------
  // Lock synchronizer
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   locked_s;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
    locked_s = sync_q[SYNC_STAGES-1];
  end

  // ---------------------------------------------------------------------------
  // Lock filter: lock_ok only changes after LOCK_FILTER consecutive
  // disagreeing samples, so shorter glitches in either direction are dropped.
  // ---------------------------------------------------------------------------
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             lock_ok_q, lock_ok_d;

  always_comb begin
    filt_cnt_d = '0;
    lock_ok_d  = lock_ok_q;
    if (locked_s != lock_ok_q) begin
      if (filt_cnt_q == FiltLast) begin
        // This sample is the LOCK_FILTER-th disagreement in a row.
        lock_ok_d  = locked_s;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with shared hold / power-up timer
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       loss_cnt_q, loss_cnt_d;
  logic             lost;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    loss_cnt_d = loss_cnt_q;
    lost       = 1'b0;

    unique case (state_q)
      StWaitLock: begin
        timer_d = '0;
        if (lock_ok_q) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!lock_ok_q) begin
          lost = 1'b1;
        end else if (timer_q == HoldLast) begin
          state_d = StPwrup;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StPwrup: begin
        if (!lock_ok_q) begin
          lost = 1'b1;
        end else if (timer_q == PwrupLast) begin
          state_d = StReady;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StReady: begin
        if (!lock_ok_q) begin
          lost = 1'b1;
        end
      end
      default: begin
        state_d = StWaitLock;
        timer_d = '0;
      end
    endcase

    // Lock loss wins over any timer expiry evaluated above.
    if (lost) begin
      state_d = StWaitLock;
      timer_d = '0;
      if (loss_cnt_q != 8'hFF) begin
        loss_cnt_d = loss_cnt_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so they change on the
  // same edge the FSM moves.
  // ---------------------------------------------------------------------------
  logic sys_rst_n_q, sys_rst_n_d;
  logic init_start_q, init_start_d;
  logic sdram_ready_q, sdram_ready_d;

  always_comb begin
    sys_rst_n_d   = (state_d == StPwrup) || (state_d == StReady);
    sdram_ready_d = (state_d == StReady);
    init_start_d  = (state_d == StReady) && (state_q != StReady);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      filt_cnt_q    <= '0;
      lock_ok_q     <= 1'b0;
      state_q       <= StWaitLock;
      timer_q       <= '0;
      loss_cnt_q    <= '0;
      sys_rst_n_q   <= 1'b0;
      init_start_q  <= 1'b0;
      sdram_ready_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      filt_cnt_q    <= filt_cnt_d;
      lock_ok_q     <= lock_ok_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      loss_cnt_q    <= loss_cnt_d;
      sys_rst_n_q   <= sys_rst_n_d;
      init_start_q  <= init_start_d;
      sdram_ready_q <= sdram_ready_d;
    end
  end

  assign sys_rst_n     = sys_rst_n_q;
  assign init_start    = init_start_q;
  assign sdram_ready   = sdram_ready_q;
  assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_sdram_reset_seq.sv
// Directed bench for sdram_reset_seq with PWRUP_CYCLES=100, other parameters
// at default (S=2, F=4, H=16): sys_rst_n rises at edge 22, init_start at 122.

module tb_sdram_reset_seq;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       sys_rst_n;
  logic       init_start;
  logic       sdram_ready;
  logic [7:0] lock_loss_cnt;

  int total = 0;
  int bad   = 0;
  int init_hi = 0;
  int exp_loss;

  sdram_reset_seq #(
    .SYNC_STAGES (2),
    .LOCK_FILTER (4),
    .RST_HOLD    (16),
    .PWRUP_CYCLES(100),
    .CNT_W       (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .sys_rst_n    (sys_rst_n),
    .init_start   (init_start),
    .sdram_ready  (sdram_ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every cycle init_start is seen high, to catch wide or stray pulses.
  always @(posedge clk) begin
    #1;
    if (init_start === 1'b1) init_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #3;
    check("rst sys_rst_n", 32'(sys_rst_n), 0);
    check("rst init_start", 32'(init_start), 0);
    check("rst sdram_ready", 32'(sdram_ready), 0);
    check("rst loss_cnt", 32'(lock_loss_cnt), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Power-up: next edge is edge 0.
    pll_locked = 1'b1;
    tick(22);
    check("pu sys_rst_n@21", 32'(sys_rst_n), 0);
    tick(1);
    check("pu sys_rst_n@22", 32'(sys_rst_n), 1);
    check("pu ready@22", 32'(sdram_ready), 0);
    tick(99);
    check("pu init@121", 32'(init_start), 0);
    check("pu ready@121", 32'(sdram_ready), 0);
    tick(1);
    check("pu init@122", 32'(init_start), 1);
    check("pu ready@122", 32'(sdram_ready), 1);
    tick(1);
    check("pu init@123", 32'(init_start), 0);
    check("pu ready@123", 32'(sdram_ready), 1);

    // 3-cycle glitch is filtered out.
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    tick(15);
    check("glitch sys_rst_n", 32'(sys_rst_n), 1);
    check("glitch ready", 32'(sdram_ready), 1);
    check("glitch loss_cnt", 32'(lock_loss_cnt), 0);

    // 10-cycle loss, then relock.
    pll_locked = 1'b0;
    tick(6);
    check("loss sys_rst_n@5", 32'(sys_rst_n), 1);
    tick(1);
    check("loss sys_rst_n@6", 32'(sys_rst_n), 0);
    check("loss ready@6", 32'(sdram_ready), 0);
    check("loss cnt@6", 32'(lock_loss_cnt), 1);
    tick(3);
    pll_locked = 1'b1;
    tick(23);
    check("relock sys_rst_n@22", 32'(sys_rst_n), 1);
    tick(99);
    check("relock init@121", 32'(init_start), 0);
    tick(1);
    check("relock init@122", 32'(init_start), 1);
    check("relock ready@122", 32'(sdram_ready), 1);

    // Loss again, relock into PWRUP, then asynchronous reset mid-cycle.
    pll_locked = 1'b0;
    tick(7);
    check("loss2 cnt", 32'(lock_loss_cnt), 2);
    tick(3);
    pll_locked = 1'b1;
    tick(53);
    check("pwrup sys_rst_n", 32'(sys_rst_n), 1);
    check("pwrup ready", 32'(sdram_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async sys_rst_n", 32'(sys_rst_n), 0);
    check("async ready", 32'(sdram_ready), 0);
    check("async init", 32'(init_start), 0);
    check("async loss_cnt", 32'(lock_loss_cnt), 0);
    tick(2);
    rst_n = 1'b1;
    tick(22);
    check("restart sys_rst_n@21", 32'(sys_rst_n), 0);
    tick(1);
    check("restart sys_rst_n@22", 32'(sys_rst_n), 1);
    tick(100);
    check("restart init@122", 32'(init_start), 1);

    // Loss whose lock_ok fall coincides with PWRUP timer reaching P-1.
    pll_locked = 1'b0;
    tick(7);
    check("loss3 cnt", 32'(lock_loss_cnt), 1);
    tick(3);
    pll_locked = 1'b1;
    tick(116);
    pll_locked = 1'b0;  // sampled low at edge 116
    tick(6);
    check("race sys_rst_n@121", 32'(sys_rst_n), 1);
    check("race init@121", 32'(init_start), 0);
    tick(1);
    check("race init@122", 32'(init_start), 0);
    check("race ready@122", 32'(sdram_ready), 0);
    check("race sys_rst_n@122", 32'(sys_rst_n), 0);
    check("race loss_cnt", 32'(lock_loss_cnt), 2);

    // 300 lock-loss events: counter must stick at 255.
    tick(10);
    exp_loss = 2;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      tick(8);
      pll_locked = 1'b0;
      tick(8);
      if (exp_loss < 255) exp_loss++;
      check("sat loss_cnt", 32'(lock_loss_cnt), 32'(exp_loss));
    end
    check("sat final", 32'(lock_loss_cnt), 255);
    check("sat sys_rst_n", 32'(sys_rst_n), 0);

    tick(2);
    check("init_start cycles", 32'(init_hi), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
